// File: rtl/muntjac_fpu_div_sqrt_iter.sv
// muntjac_fpu_div_sqrt_iter
//
// Iterative radix-2 divide / square-root unit for the FPU long-latency path.
// Operands arrive unpacked (sign, signed unbiased exponent of 1.f, fraction,
// class flags). The unit produces one quotient/root bit per cycle for
// N = SigWidth+3 cycles, then presents an exact truncated result with the
// sticky bit folded into the significand LSB. Special operands skip the
// iteration and answer in the cycle after acceptance.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. Request: req_valid_i / req_ready_o (ready only while idle).
// Response: resp_valid_o / resp_ready_i; response fields hold steady while
// resp_valid_o is high and resp_ready_i is low.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i, req_ready_o       request handshake
//   is_sqrt_i                      1 = sqrt(a), b ignored
//   rounding_mode_i / _o           passed through, captured on accept
//   a_*_i, b_*_i                   unpacked operands and class flags
//   flush_i                        abort any operation, no response
//   resp_valid_o, resp_ready_i     response handshake
//   sign_o, is_zero_o, is_nan_o, is_inf_o   result class
//   invalid_operation_o, divide_by_zero_o   exception causes
//   exponent_o, significand_o      unbiased exponent, fraction below leading one
module muntjac_fpu_div_sqrt_iter #(
   parameter int unsigned ExpWidth = 13,
   parameter int unsigned SigWidth = 52
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic                       is_sqrt_i,
   input  logic [2:0]                 rounding_mode_i,
   input  logic                       a_sign_i,
   input  logic                       b_sign_i,
   input  logic signed [ExpWidth-1:0] a_exponent_i,
   input  logic signed [ExpWidth-1:0] b_exponent_i,
   input  logic [SigWidth-1:0]        a_significand_i,
   input  logic [SigWidth-1:0]        b_significand_i,
   input  logic                       a_is_zero_i,
   input  logic                       a_is_inf_i,
   input  logic                       a_is_nan_i,
   input  logic                       a_is_snan_i,
   input  logic                       b_is_zero_i,
   input  logic                       b_is_inf_i,
   input  logic                       b_is_nan_i,
   input  logic                       b_is_snan_i,
   input  logic                       flush_i,
   output logic                       resp_valid_o,
   input  logic                       resp_ready_i,
   output logic                       sign_o,
   output logic                       is_zero_o,
   output logic                       is_nan_o,
   output logic                       is_inf_o,
   output logic                       invalid_operation_o,
   output logic                       divide_by_zero_o,
   output logic signed [ExpWidth-1:0] exponent_o,
   output logic [SigWidth+1:0]        significand_o,
   output logic [2:0]                 rounding_mode_o
);

   localparam int unsigned N        = SigWidth + 3;
   // The sqrt remainder grows to just over twice the partial root; four
   // guard bits above the root width cover it and the divide remainder.
   localparam int unsigned RemWidth = N + 4;
   localparam int unsigned CntWidth = $clog2(N + 1);

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e                      state_q;
   logic [CntWidth-1:0]         count_q;
   logic                        is_sqrt_q;
   logic                        sign_q;
   logic signed [ExpWidth-1:0]  exp_q;
   logic [RemWidth-1:0]         rem_q;
   logic [SigWidth:0]           div_q;
   logic [SigWidth+1:0]         rad_q;
   logic [N-1:0]                quo_q;

   assign req_ready_o = (state_q == StIdle);

   // ---------------------------------------------------------------
   // Special-operand classification of the incoming request
   // ---------------------------------------------------------------
   logic sp_hit, sp_sign, sp_zero, sp_nan, sp_inf, sp_inv, sp_dbz;

   always_comb begin
      sp_hit  = 1'b0;
      sp_sign = 1'b0;
      sp_zero = 1'b0;
      sp_nan  = 1'b0;
      sp_inf  = 1'b0;
      sp_inv  = 1'b0;
      sp_dbz  = 1'b0;
      if (is_sqrt_i) begin
         if (a_is_nan_i) begin
            sp_hit = 1'b1;
            sp_nan = 1'b1;
            sp_inv = a_is_snan_i;
         end else if (a_is_zero_i) begin
            // sqrt(-0) = -0
            sp_hit  = 1'b1;
            sp_zero = 1'b1;
            sp_sign = a_sign_i;
         end else if (a_sign_i) begin
            sp_hit = 1'b1;
            sp_nan = 1'b1;
            sp_inv = 1'b1;
         end else if (a_is_inf_i) begin
            sp_hit = 1'b1;
            sp_inf = 1'b1;
         end
      end else begin
         if (a_is_nan_i || b_is_nan_i) begin
            sp_hit = 1'b1;
            sp_nan = 1'b1;
            sp_inv = a_is_snan_i | b_is_snan_i;
         end else if ((a_is_inf_i && b_is_inf_i) || (a_is_zero_i && b_is_zero_i)) begin
            sp_hit = 1'b1;
            sp_nan = 1'b1;
            sp_inv = 1'b1;
         end else if (b_is_zero_i) begin
            sp_hit  = 1'b1;
            sp_inf  = 1'b1;
            sp_dbz  = 1'b1;
            sp_sign = a_sign_i ^ b_sign_i;
         end else if (a_is_inf_i) begin
            sp_hit  = 1'b1;
            sp_inf  = 1'b1;
            sp_sign = a_sign_i ^ b_sign_i;
         end else if (a_is_zero_i || b_is_inf_i) begin
            sp_hit  = 1'b1;
            sp_zero = 1'b1;
            sp_sign = a_sign_i ^ b_sign_i;
         end
      end
   end

   // ---------------------------------------------------------------
   // One recurrence step plus final normalisation of its result
   // ---------------------------------------------------------------
   logic                        q_bit;
   logic                        sticky;
   logic [RemWidth-1:0]         rem_next;
   logic [RemWidth-1:0]         sqrt_shift;
   logic [RemWidth-1:0]         sqrt_trial;
   logic [RemWidth-1:0]         div_ext;
   logic [SigWidth+1:0]         rad_next;
   logic [N-1:0]                quo_next;
   logic [SigWidth+1:0]         res_sig;
   logic signed [ExpWidth-1:0]  res_exp;

   always_comb begin
      q_bit      = 1'b0;
      rem_next   = rem_q;
      rad_next   = rad_q;
      // Restoring sqrt: bring down the next radicand bit pair and try
      // subtracting 4*root + 1.
      sqrt_shift = {rem_q[RemWidth-3:0], rad_q[SigWidth+1:SigWidth]};
      sqrt_trial = {2'b00, quo_q, 2'b01};
      div_ext    = {{(RemWidth-SigWidth-1){1'b0}}, div_q};
      if (is_sqrt_q) begin
         q_bit    = (sqrt_shift >= sqrt_trial);
         rem_next = q_bit ? (sqrt_shift - sqrt_trial) : sqrt_shift;
         rad_next = rad_q << 2;
      end else begin
         q_bit    = (rem_q >= div_ext);
         rem_next = (q_bit ? (rem_q - div_ext) : rem_q) << 1;
      end
      quo_next = {quo_q[N-2:0], q_bit};
      sticky   = (rem_next != '0);
      // The root always has its top bit set; a quotient below one needs a
      // single left shift to put the leading one on top.
      if (is_sqrt_q || quo_next[N-1]) begin
         res_sig = quo_next[N-2:0];
         res_exp = exp_q;
      end else begin
         res_sig = {quo_next[N-3:0], 1'b0};
         res_exp = exp_q - ExpWidth'(1);
      end
      res_sig[0] = res_sig[0] | sticky;
   end

   // ---------------------------------------------------------------
   // Control FSM and registered response
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= StIdle;
         count_q             <= '0;
         is_sqrt_q           <= 1'b0;
         sign_q              <= 1'b0;
         exp_q               <= '0;
         rem_q               <= '0;
         div_q               <= '0;
         rad_q               <= '0;
         quo_q               <= '0;
         resp_valid_o        <= 1'b0;
         sign_o              <= 1'b0;
         is_zero_o           <= 1'b0;
         is_nan_o            <= 1'b0;
         is_inf_o            <= 1'b0;
         invalid_operation_o <= 1'b0;
         divide_by_zero_o    <= 1'b0;
         exponent_o          <= '0;
         significand_o       <= '0;
         rounding_mode_o     <= '0;
      end else if (flush_i) begin
         // Flush beats every transition, including a completing handshake.
         state_q      <= StIdle;
         resp_valid_o <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  rounding_mode_o <= rounding_mode_i;
                  is_sqrt_q       <= is_sqrt_i;
                  count_q         <= '0;
                  quo_q           <= '0;
                  div_q           <= {1'b1, b_significand_i};
                  if (sp_hit) begin
                     sign_o              <= sp_sign;
                     is_zero_o           <= sp_zero;
                     is_nan_o            <= sp_nan;
                     is_inf_o            <= sp_inf;
                     invalid_operation_o <= sp_inv;
                     divide_by_zero_o    <= sp_dbz;
                     exponent_o          <= '0;
                     significand_o       <= '0;
                     resp_valid_o        <= 1'b1;
                     state_q             <= StDone;
                  end else begin
                     if (is_sqrt_i) begin
                        sign_q <= a_sign_i;
                        rem_q  <= '0;
                        // Odd exponent: double the radicand so the halved
                        // exponent stays integral; ea>>>1 equals (ea-1)>>>1
                        // for odd ea, so one shift serves both cases.
                        rad_q  <= a_exponent_i[0] ? {1'b1, a_significand_i, 1'b0}
                                                  : {2'b01, a_significand_i};
                        exp_q  <= a_exponent_i >>> 1;
                     end else begin
                        sign_q <= a_sign_i ^ b_sign_i;
                        rem_q  <= {{(RemWidth-SigWidth-1){1'b0}}, 1'b1, a_significand_i};
                        rad_q  <= '0;
                        exp_q  <= a_exponent_i - b_exponent_i;
                     end
                     state_q <= StBusy;
                  end
               end
            end
            StBusy: begin
               rem_q   <= rem_next;
               rad_q   <= rad_next;
               quo_q   <= quo_next;
               count_q <= count_q + CntWidth'(1);
               if (count_q == CntWidth'(N - 1)) begin
                  sign_o              <= sign_q;
                  is_zero_o           <= 1'b0;
                  is_nan_o            <= 1'b0;
                  is_inf_o            <= 1'b0;
                  invalid_operation_o <= 1'b0;
                  divide_by_zero_o    <= 1'b0;
                  exponent_o          <= res_exp;
                  significand_o       <= res_sig;
                  resp_valid_o        <= 1'b1;
                  state_q             <= StDone;
               end
            end
            StDone: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: begin
               state_q      <= StIdle;
               resp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muntjac_fpu_div_sqrt_iter.sv
// Testbench for muntjac_fpu_div_sqrt_iter: directed test-plan cases with
// literal expectations, randomized operations checked against an arithmetic
// reference model (big-integer division and integer square root), plus
// back-pressure, flush and mid-operation reset scenarios.
module tb_muntjac_fpu_div_sqrt_iter;

   localparam int EW = 13;
   localparam int SW = 52;
   localparam int N  = SW + 3;
   localparam int OW = SW + 2;

   logic                 clk_i;
   logic                 rst_ni;
   logic                 req_valid_i;
   logic                 req_ready_o;
   logic                 is_sqrt_i;
   logic [2:0]           rounding_mode_i;
   logic                 a_sign_i, b_sign_i;
   logic signed [EW-1:0] a_exponent_i, b_exponent_i;
   logic [SW-1:0]        a_significand_i, b_significand_i;
   logic                 a_is_zero_i, a_is_inf_i, a_is_nan_i, a_is_snan_i;
   logic                 b_is_zero_i, b_is_inf_i, b_is_nan_i, b_is_snan_i;
   logic                 flush_i;
   logic                 resp_valid_o;
   logic                 resp_ready_i;
   logic                 sign_o, is_zero_o, is_nan_o, is_inf_o;
   logic                 invalid_operation_o, divide_by_zero_o;
   logic signed [EW-1:0] exponent_o;
   logic [OW-1:0]        significand_o;
   logic [2:0]           rounding_mode_o;

   muntjac_fpu_div_sqrt_iter #(.ExpWidth(EW), .SigWidth(SW)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .req_valid_i         (req_valid_i),
      .req_ready_o         (req_ready_o),
      .is_sqrt_i           (is_sqrt_i),
      .rounding_mode_i     (rounding_mode_i),
      .a_sign_i            (a_sign_i),
      .b_sign_i            (b_sign_i),
      .a_exponent_i        (a_exponent_i),
      .b_exponent_i        (b_exponent_i),
      .a_significand_i     (a_significand_i),
      .b_significand_i     (b_significand_i),
      .a_is_zero_i         (a_is_zero_i),
      .a_is_inf_i          (a_is_inf_i),
      .a_is_nan_i          (a_is_nan_i),
      .a_is_snan_i         (a_is_snan_i),
      .b_is_zero_i         (b_is_zero_i),
      .b_is_inf_i          (b_is_inf_i),
      .b_is_nan_i          (b_is_nan_i),
      .b_is_snan_i         (b_is_snan_i),
      .flush_i             (flush_i),
      .resp_valid_o        (resp_valid_o),
      .resp_ready_i        (resp_ready_i),
      .sign_o              (sign_o),
      .is_zero_o           (is_zero_o),
      .is_nan_o            (is_nan_o),
      .is_inf_o            (is_inf_o),
      .invalid_operation_o (invalid_operation_o),
      .divide_by_zero_o    (divide_by_zero_o),
      .exponent_o          (exponent_o),
      .significand_o       (significand_o),
      .rounding_mode_o     (rounding_mode_o)
   );

   // ---------------- clock ----------------
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // ---------------- scoreboard ----------------
   // Expected response layout:
   // {sign, zero, nan, inf, invalid, dbz, exponent[12:0], significand[53:0], rm[2:0]}
   int          checks = 0;
   int          errors = 0;
   logic [75:0] exp_q[$];

   localparam logic [3:0] CLS_NORM = 4'b0000;
   localparam logic [3:0] CLS_ZERO = 4'b1000;
   localparam logic [3:0] CLS_INF  = 4'b0100;
   localparam logic [3:0] CLS_QNAN = 4'b0010;
   localparam logic [3:0] CLS_SNAN = 4'b0011;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [75:0] pack_exp(input logic s, input logic z, input logic nn,
                                            input logic inf, input logic inv, input logic dbz,
                                            input int e, input logic [OW-1:0] sig,
                                            input logic [2:0] rm);
      logic [EW-1:0] et;
      et = e[EW-1:0];
      return {s, z, nn, inf, inv, dbz, et, sig, rm};
   endfunction

   // Reference model: IEEE-style special rules, then exact big-integer
   // quotient / integer square root truncated to 55 significant bits.
   function automatic logic [75:0] model(input logic sq, input logic [2:0] rm,
                                         input logic as, input int ea, input logic [SW-1:0] fa,
                                         input logic [3:0] ac,
                                         input logic bs, input int eb, input logic [SW-1:0] fb,
                                         input logic [3:0] bc);
      logic s, z, nn, inf, inv, dbz, odd;
      int e;
      logic [OW-1:0] sig;
      logic [127:0] num, den, q, r, x, root, cand;
      s = 0; z = 0; nn = 0; inf = 0; inv = 0; dbz = 0; e = 0; sig = '0;
      if (!sq) begin
         if (ac[1] | bc[1]) begin
            nn = 1; inv = ac[0] | bc[0];
         end else if ((ac[2] & bc[2]) | (ac[3] & bc[3])) begin
            nn = 1; inv = 1;
         end else if (bc[3]) begin
            inf = 1; dbz = 1; s = as ^ bs;
         end else if (ac[2]) begin
            inf = 1; s = as ^ bs;
         end else if (ac[3] | bc[2]) begin
            z = 1; s = as ^ bs;
         end else begin
            s   = as ^ bs;
            num = {75'b0, 1'b1, fa} << 54;
            den = {75'b0, 1'b1, fb};
            q   = num / den;
            r   = num % den;
            if (q[54]) begin
               sig = q[53:0];
               e   = ea - eb;
            end else begin
               sig = {q[52:0], 1'b0};
               e   = ea - eb - 1;
            end
            sig[0] = sig[0] | (r != 0);
         end
      end else begin
         if (ac[1]) begin
            nn = 1; inv = ac[0];
         end else if (ac[3]) begin
            z = 1; s = as;
         end else if (as) begin
            nn = 1; inv = 1;
         end else if (ac[2]) begin
            inf = 1;
         end else begin
            odd  = (ea % 2) != 0;
            x    = {75'b0, 1'b1, fa} << (odd ? 57 : 56);
            e    = odd ? (ea - 1) / 2 : ea / 2;
            root = '0;
            for (int b = 54; b >= 0; b--) begin
               cand = root | (128'd1 << b);
               if (cand * cand <= x) root = cand;
            end
            sig = root[53:0];
            sig[0] = sig[0] | (root * root != x);
         end
      end
      return pack_exp(s, z, nn, inf, inv, dbz, e, sig, rm);
   endfunction

   function automatic logic [3:0] rand_cls();
      int k;
      k = int'($urandom_range(0, 15));
      case (k)
         0:       return CLS_ZERO;
         1:       return CLS_INF;
         2:       return CLS_QNAN;
         3:       return CLS_SNAN;
         default: return CLS_NORM;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_operands(input logic sq, input logic [2:0] rm,
                               input logic as, input int ea, input logic [SW-1:0] fa,
                               input logic [3:0] ac,
                               input logic bs, input int eb, input logic [SW-1:0] fb,
                               input logic [3:0] bc);
      is_sqrt_i       = sq;
      rounding_mode_i = rm;
      a_sign_i        = as;
      a_exponent_i    = ea[EW-1:0];
      a_significand_i = fa;
      {a_is_zero_i, a_is_inf_i, a_is_nan_i, a_is_snan_i} = ac;
      b_sign_i        = bs;
      b_exponent_i    = eb[EW-1:0];
      b_significand_i = fb;
      {b_is_zero_i, b_is_inf_i, b_is_nan_i, b_is_snan_i} = bc;
   endtask

   task automatic check_fields(input logic [75:0] e);
      logic [EW-1:0] oe;
      oe = exponent_o;
      check("sign", sign_o, e[75]);
      check("is_zero", is_zero_o, e[74]);
      check("is_nan", is_nan_o, e[73]);
      check("is_inf", is_inf_o, e[72]);
      check("invalid", invalid_operation_o, e[71]);
      check("div_by_zero", divide_by_zero_o, e[70]);
      check("exponent", oe, e[69:57]);
      check("significand", significand_o, e[56:3]);
      check("rounding_mode", rounding_mode_o, e[2:0]);
   endtask

   // Issues the operands currently on the bus, measures the latency, checks
   // the response against the scoreboard head, optionally stalls the
   // consumer for 'hold' cycles, then completes the handshake.
   // Entered and left just after a falling edge.
   task automatic issue_and_check(input int hold);
      logic [75:0] e;
      int lat, exp_lat;
      check("req_ready_idle", req_ready_o, 1);
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      lat = 1;
      while (!resp_valid_o && lat < 200) begin
         @(negedge clk_i);
         lat++;
      end
      e = exp_q.pop_front();
      exp_lat = (e[74] | e[73] | e[72]) ? 1 : N + 1;
      check("latency", 64'(lat), 64'(exp_lat));
      if (resp_valid_o) begin
         check_fields(e);
         for (int k = 0; k < hold; k++) begin
            @(negedge clk_i);
            check("hold_valid", resp_valid_o, 1);
            check("hold_ready_low", req_ready_o, 0);
            check_fields(e);
         end
         resp_ready_i = 1'b1;
         @(negedge clk_i);
         resp_ready_i = 1'b0;
         check("valid_drops", resp_valid_o, 0);
         check("ready_returns", req_ready_o, 1);
      end
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic          sq, as, bs;
      logic [2:0]    rm;
      logic [3:0]    ac, bc;
      logic [63:0]   ra, rb;
      int            ea, eb, lat, seen;
      logic [OW-1:0] sig_sqrt2;

      rst_ni       = 1'b0;
      req_valid_i  = 1'b0;
      resp_ready_i = 1'b0;
      flush_i      = 1'b0;
      set_operands(0, 3'd0, 0, 0, '0, CLS_NORM, 0, 0, '0, CLS_NORM);
      repeat (3) @(negedge clk_i);

      // Reset state
      check("rst_req_ready", req_ready_o, 1);
      check("rst_resp_valid", resp_valid_o, 0);
      check("rst_exponent", exponent_o, 0);
      check("rst_significand", significand_o, 0);
      check("rst_flags", {sign_o, is_zero_o, is_nan_o, is_inf_o, invalid_operation_o,
                          divide_by_zero_o}, 0);
      check("rst_rm", rounding_mode_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // 6.0 / 2.0 = 1.1b * 2^1
      set_operands(0, 3'd1, 0, 2, 52'h8000000000000, CLS_NORM, 0, 1, '0, CLS_NORM);
      exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0, 1, {1'b1, 53'b0}, 3'd1));
      issue_and_check(0);

      // 1.0 / 3.0 = 1.0101...b * 2^-2, inexact
      set_operands(0, 3'd2, 0, 0, '0, CLS_NORM, 0, 1, 52'h8000000000000, CLS_NORM);
      exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0, -2, 54'h15555555555555, 3'd2));
      issue_and_check(0);

      // sqrt(4.0) = 1.0 * 2^1
      set_operands(1, 3'd3, 0, 2, '0, CLS_NORM, 0, 0, '0, CLS_NORM);
      exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0, 1, '0, 3'd3));
      issue_and_check(0);

      // sqrt(2.0) = 0x1.6A09E667F3BCC9... ; next two bits 10, sticky sets LSB
      sig_sqrt2 = {52'h6A09E667F3BCC, 2'b11};
      set_operands(1, 3'd4, 0, 1, '0, CLS_NORM, 0, 0, '0, CLS_NORM);
      exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0, 0, sig_sqrt2, 3'd4));
      issue_and_check(0);

      // Specials
      set_operands(0, 3'd1, 0, 0, '0, CLS_NORM, 0, 0, '0, CLS_ZERO);       // 1/0
      exp_q.push_back(pack_exp(0, 0, 0, 1, 0, 1, 0, '0, 3'd1));
      issue_and_check(0);
      set_operands(0, 3'd2, 0, 0, '0, CLS_ZERO, 0, 0, '0, CLS_ZERO);       // 0/0
      exp_q.push_back(pack_exp(0, 0, 1, 0, 1, 0, 0, '0, 3'd2));
      issue_and_check(0);
      set_operands(1, 3'd3, 1, 0, '0, CLS_NORM, 0, 0, '0, CLS_NORM);       // sqrt(-1)
      exp_q.push_back(pack_exp(0, 0, 1, 0, 1, 0, 0, '0, 3'd3));
      issue_and_check(0);
      set_operands(1, 3'd4, 1, 0, '0, CLS_ZERO, 0, 0, '0, CLS_NORM);       // sqrt(-0)
      exp_q.push_back(pack_exp(1, 1, 0, 0, 0, 0, 0, '0, 3'd4));
      issue_and_check(0);
      set_operands(0, 3'd0, 1, 0, '0, CLS_QNAN, 1, 0, '0, CLS_NORM);       // qNaN/1
      exp_q.push_back(pack_exp(0, 0, 1, 0, 0, 0, 0, '0, 3'd0));
      issue_and_check(0);
      set_operands(0, 3'd1, 0, 0, '0, CLS_SNAN, 0, 0, '0, CLS_NORM);       // sNaN/1
      exp_q.push_back(pack_exp(0, 0, 1, 0, 1, 0, 0, '0, 3'd1));
      issue_and_check(0);

      // Consumer back-pressure: -6.0 / 2.0 held for 10 cycles
      set_operands(0, 3'd2, 1, 2, 52'h8000000000000, CLS_NORM, 0, 1, '0, CLS_NORM);
      exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 0, 1, {1'b1, 53'b0}, 3'd2));
      issue_and_check(10);

      // Significand boundaries against the model
      ra = {$urandom, $urandom};
      set_operands(0, 3'd3, 0, 5, ra[51:0], CLS_NORM, 1, 5, ra[51:0], CLS_NORM);  // fa == fb
      exp_q.push_back(model(0, 3'd3, 0, 5, ra[51:0], CLS_NORM, 1, 5, ra[51:0], CLS_NORM));
      issue_and_check(0);
      set_operands(0, 3'd0, 0, 0, '1, CLS_NORM, 0, 0, '0, CLS_NORM);
      exp_q.push_back(model(0, 3'd0, 0, 0, '1, CLS_NORM, 0, 0, '0, CLS_NORM));
      issue_and_check(0);
      set_operands(0, 3'd0, 0, -7, '0, CLS_NORM, 0, 9, '1, CLS_NORM);
      exp_q.push_back(model(0, 3'd0, 0, -7, '0, CLS_NORM, 0, 9, '1, CLS_NORM));
      issue_and_check(0);
      set_operands(1, 3'd1, 0, -3, '1, CLS_NORM, 0, 0, '0, CLS_NORM);
      exp_q.push_back(model(1, 3'd1, 0, -3, '1, CLS_NORM, 0, 0, '0, CLS_NORM));
      issue_and_check(0);
      set_operands(1, 3'd1, 0, -4, '1, CLS_NORM, 0, 0, '0, CLS_NORM);
      exp_q.push_back(model(1, 3'd1, 0, -4, '1, CLS_NORM, 0, 0, '0, CLS_NORM));
      issue_and_check(0);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         sq = 1'($urandom_range(0, 1));
         rm = 3'($urandom_range(0, 4));
         as = sq ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
         bs = 1'($urandom_range(0, 1));
         ea = int'($urandom_range(0, 120)) - 60;
         eb = int'($urandom_range(0, 120)) - 60;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         ac = rand_cls();
         bc = rand_cls();
         set_operands(sq, rm, as, ea, ra[51:0], ac, bs, eb, rb[51:0], bc);
         exp_q.push_back(model(sq, rm, as, ea, ra[51:0], ac, bs, eb, rb[51:0], bc));
         issue_and_check(0);
      end

      // Flush during iteration 20: no response ever appears
      set_operands(0, 3'd2, 0, 3, 52'h123456789ABCD, CLS_NORM, 0, 1, 52'h0F0F0F0F0F0F0, CLS_NORM);
      check("flush_ready_before", req_ready_o, 1);
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      repeat (19) @(negedge clk_i);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      check("flush_no_valid", resp_valid_o, 0);
      check("flush_ready", req_ready_o, 1);
      seen = 0;
      for (int k = 0; k < 70; k++) begin
         @(negedge clk_i);
         if (resp_valid_o) seen++;
      end
      check("flush_no_response", 64'(seen), 0);

      // Flush while Done with resp_ready high: flush wins, response dropped
      set_operands(0, 3'd1, 0, 0, '0, CLS_NORM, 0, 0, '0, CLS_ZERO);
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      lat = 1;
      while (!resp_valid_o && lat < 10) begin
         @(negedge clk_i);
         lat++;
      end
      check("flush_done_latency", 64'(lat), 1);
      flush_i      = 1'b1;
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      flush_i      = 1'b0;
      resp_ready_i = 1'b0;
      check("flush_done_valid", resp_valid_o, 0);
      check("flush_done_ready", req_ready_o, 1);

      // A completed op leaves nonzero outputs, then reset mid-iteration
      set_operands(0, 3'd3, 1, 4, 52'h8000000000000, CLS_NORM, 0, 1, '0, CLS_NORM);
      exp_q.push_back(pack_exp(1, 0, 0, 0, 0, 0, 3, {1'b1, 53'b0}, 3'd3));
      issue_and_check(0);
      set_operands(1, 3'd4, 0, 9, 52'hABCDEF0123456, CLS_NORM, 0, 0, '0, CLS_NORM);
      req_valid_i = 1'b1;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      repeat (20) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("arst_valid", resp_valid_o, 0);
      check("arst_ready", req_ready_o, 1);
      check("arst_exponent", exponent_o, 0);
      check("arst_significand", significand_o, 0);
      check("arst_sign", sign_o, 0);
      check("arst_rm", rounding_mode_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Recovery after reset: 6.0 / 2.0 again
      set_operands(0, 3'd1, 0, 2, 52'h8000000000000, CLS_NORM, 0, 1, '0, CLS_NORM);
      exp_q.push_back(pack_exp(0, 0, 0, 0, 0, 0, 1, {1'b1, 53'b0}, 3'd1));
      issue_and_check(0);

      // ---------------- final report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muntjac_fpu_div_sqrt_iter.md
# muntjac_fpu_div_sqrt_iter

Iterative radix-2 floating-point divide / square-root unit for the FPU's long-latency path. It accepts unpacked, pre-normalised operands and computes one quotient or root bit per cycle. It emits an exact truncated result plus sticky bit in the unpacked form consumed directly by the downstream IEEE rounding/packing stage. Special operands bypass the iteration.

## Interface
Parameters:
- ExpWidth, 13: width of signed unbiased exponents, in and out. Must hold any exponent difference of two inputs.
- SigWidth, 52: fraction width of operands, hidden one excluded.
- Derived: N = SigWidth+3 iterations; OutSigWidth = SigWidth+2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit idle, request accepted when both high
- is_sqrt_i  in  1  1 = sqrt(a); b ignored
- rounding_mode_i  in  rounding_mode_e  captured on accept
- a_sign_i, b_sign_i  in  1 each  operand signs
- a_exponent_i, b_exponent_i  in  ExpWidth (signed) each  unbiased exponent of 1.f
- a_significand_i, b_significand_i  in  SigWidth each  fraction bits
- a_is_zero_i / a_is_inf_i / a_is_nan_i / a_is_snan_i  in  1 each  class flags; same set for b
- flush_i  in  1  abort the current operation
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- sign_o, is_zero_o, is_nan_o, is_inf_o  out  1 each  result class
- invalid_operation_o, divide_by_zero_o  out  1 each  exception causes
- exponent_o  out  ExpWidth (signed)  unbiased result exponent
- significand_o  out  OutSigWidth  fraction below leading one; LSB is ORed with sticky
- rounding_mode_o  out  rounding_mode_e  captured rounding mode

## Operation
- FSM: Idle -> (accept, special) Done; Idle -> (accept, normal) Busy; Busy -> (count reaches N) Done; Done -> (resp_ready_i) Idle. In any state, flush_i -> Idle with no response.
- req_ready_o = (state == Idle). There is no overlap between operations. All inputs are registered on accept.
- Divide special cases, in priority order. Sign is a_sign ^ b_sign except for NaN.
  - Any NaN operand: is_nan, sign 0. invalid if either operand is sNaN.
  - inf/inf or 0/0: is_nan, invalid.
  - finite nonzero / 0: is_inf, divide_by_zero.
  - inf/x: is_inf.
  - 0/x or x/inf: is_zero.
- Sqrt special cases:
  - NaN: is_nan, invalid if sNaN.
  - ±0: is_zero, sign preserved.
  - Negative nonzero, including -inf: is_nan, invalid.
  - +inf: is_inf.
- Divide datapath:
  - Partial remainder is initialised to {1,fa} with SigWidth+3 bits. d = {1,fb}.
  - Each cycle: q_bit = (r >= d); if set, r -= d; then r <<= 1.
  - After N cycles Q[N-1] has weight 2^0. If Q[N-1] = 0, shift Q left by 1 and lower the exponent by 1.
  - Exponent = ea - eb, minus 1 when normalised.
- Sqrt datapath:
  - If ea is odd, the radicand is {1,fa} << 1 and exponent = (ea-1) >>> 1; otherwise exponent = ea >>> 1.
  - Restoring digit recurrence produces N root bits. The root lies in [1,2), so no normalisation step is needed.
- significand_o is the OutSigWidth bits directly below the leading one. Its LSB is ORed with (final remainder != 0) and with any dropped quotient bit.
- Outputs of special results: exponent_o = 0, significand_o = 0.
- Outputs hold stable while resp_valid_o && !resp_ready_i.

## Timing
- Reset: state Idle, req_ready_o = 1, resp_valid_o = 0, all other outputs 0.
- Accept at cycle edge 0.
  - Special result: resp_valid_o = 1 from cycle 1.
  - Normal result: N iterations run in cycles 1..N; resp_valid_o = 1 from cycle N+1. Double precision: 56 cycles.
- Back-to-back: the next accept can occur the cycle after the response handshake. req_ready_o rises combinationally from the registered Idle state.
- flush_i is sampled at the clock edge and takes priority over every transition, including Done with resp_ready_i. resp_valid_o is 0 the next cycle.
- Asynchronous reset mid-operation: immediate return to the reset values. No partial result is emitted.

## Test plan
- Divide 6.0/2.0 (ea = 2, fa = 0x8000000000000; eb = 1, fb = 0) -> after 56 cycles: exponent_o = 1, significand_o = 54'b10 followed by zeros, sign 0, no flags.
- Divide 1.0/3.0 (ea = 0, fa = 0; eb = 1, fb = 0x8000000000000) -> exponent_o = -2, significand_o = 54-bit alternating pattern 0101…01 (sticky set).
- Sqrt 4.0 (ea = 2, fa = 0) -> exponent_o = 1, significand_o = 0. Sqrt 2.0 -> exponent_o = 0, significand_o = 0x6A09E667F3BCC followed by 2 bits, inexact sticky.
- Specials, each with response at cycle 1:
  - 1.0/0 -> is_inf, divide_by_zero.
  - 0/0 -> is_nan, invalid.
  - sqrt(-1.0) -> is_nan, invalid.
  - sqrt(-0) -> is_zero, sign 1.
  - qNaN/1 -> is_nan, no invalid.
  - sNaN/1 -> is_nan, invalid.
- Hold resp_ready_i = 0 for 10 cycles: outputs stable, req_ready_o = 0. Then handshake, and a new request is accepted the following cycle.
- flush_i asserted at iteration 20: no response, req_ready_o = 1 the next cycle. Also assert rst_ni low mid-iteration: all outputs reset immediately.
